mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: WIDTH, default 32 (from shared package), datapath width.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_alu_result  in  WIDTH  effective address / ALU result from EX/MEM register.
REQ-005 mem_reg_data2  in  WIDTH  store data (rs2).
REQ-006 mem_rd  in  5 / mem_funct3  in  3 / mem_opcode  in  7  instruction fields.
REQ-007 mem_reg_wr_en, mem_mem_to_reg  in  1 each / mem_wb_sel  in  2  control.
REQ-008 dmem_req  out  1  memory request; dmem_we  out  1  1 = store.
REQ-009 dmem_addr  out  WIDTH  word address, bits [1:0] always 0.
REQ-010 dmem_wdata  out  WIDTH  lane-shifted store data; dmem_be  out  4  byte enables.
REQ-011 dmem_gnt  in  1  request accepted; dmem_rvalid  in  1  read data valid; dmem_rdata  in  WIDTH.
REQ-012 mem_stall  out  1  holds PC, IF/ID, ID/EX, EX/MEM.
REQ-013 wb_alu_result, wb_load_data  out  WIDTH; wb_rd  out  5; wb_reg_wr_en, wb_mem_to_reg  out  1; wb_wb_sel  out  2  registered MEM/WB outputs.
REQ-014 misaligned  out  1  registered one-cycle fault flag.

Function
REQ-015 Load = opcode 0000011; store = opcode 0100011; anything else passes through, never touches memory, 1-cycle latency.
REQ-016 FSM states IDLE, WAIT_GNT, WAIT_RVALID.
REQ-017 IDLE, aligned load/store: dmem_req=1 same cycle; gnt=1 -> store completes, load -> WAIT_RVALID; gnt=0 -> WAIT_GNT.
REQ-018 WAIT_GNT: hold req, we, addr, wdata, be stable until gnt; on gnt, store -> IDLE (completes), load -> WAIT_RVALID.
REQ-019 WAIT_RVALID: dmem_req=0; on rvalid, capture load data into wb_load_data, -> IDLE.
REQ-020 mem_stall=1 whenever the current memory op has not completed this cycle; 0 in the cycle of completion (store gnt or load rvalid) and for non-memory ops.
REQ-021 While mem_stall=1, MEM/WB is loaded with a bubble each edge (wb_reg_wr_en=0, wb_mem_to_reg=0).
REQ-022 Load extraction on addr[1:0]: LB/LBU (000/100) select byte, sign/zero extend; LH/LHU (001/101) select halfword [1]; LW (010) full word.
REQ-023 Store: SB be=0001<<addr[1:0], data byte replicated to all lanes; SH be=0011<<addr[1:0], halfword replicated; SW be=1111.
REQ-024 Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no request, no stall, retired as bubble with wb_reg_wr_en=0, misaligned=1 for one cycle.
REQ-025 Stores always write wb_reg_wr_en=0 regardless of mem_reg_wr_en.
REQ-026 Unsupported funct3 on load/store treated as misaligned.
REQ-027 rvalid or gnt outside the expected state is ignored.

Reset
REQ-028 rst forces FSM to IDLE and all wb_* outputs, misaligned to 0 at the next edge; overrides any other event.
REQ-029 Reset mid-transaction drops dmem_req the same cycle rst is sampled; an outstanding rvalid after reset is ignored.
REQ-030 mem_stall=0 during reset.

Structure
REQ-031 WIDTH, opcode constants, funct3 load/store encodings and FSM state typedef reside in shared package all_pkgs.
REQ-032 Combinational load extract / store align logic in one sub-module, lsu_align; FSM and MEM/WB register in mem_stage.

Verification
REQ-033 ALU op, alu_result=0x0000_1234, rd=5 -> next cycle wb_alu_result=0x1234, wb_rd=5, wb_reg_wr_en=1, stall never 1.
REQ-034 LB addr 0x103, gnt same cycle, rvalid next with rdata=0x80FF_FFFF -> 1 stall cycle, wb_load_data=0xFFFF_FF80.
REQ-035 SH addr 0x102, data 0x0000_BEEF, gnt delayed 3 cycles -> dmem_be=1100, wdata=0xBEEF_BEEF, addr=0x100 stable, stall=1 for 3 cycles, wb_reg_wr_en=0.
REQ-036 LW addr 0x101 -> no dmem_req, misaligned=1 one cycle, wb_reg_wr_en=0, no stall.
REQ-037 LHU addr 0x102 in WAIT_RVALID, rst asserted -> next edge IDLE, req=0, stall=0; late rvalid ignored.
REQ-038 Back-to-back SW then LW with gnt and rvalid immediate -> store completes no stall, load stalls exactly 1 cycle.

Source files
------------

// File: rtl/all_pkgs.sv
// Shared constants and types for the MEM pipeline stage: datapath width,
// RV32 load/store opcodes, funct3 access-size encodings and the MEM FSM states.
package all_pkgs;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 encodings shared by loads and stores (BU/HU are load-only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } mem_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the MEM stage: word address, store lane
// alignment/byte enables, load extraction and misalignment/illegal-size detection.
module lsu_align
  import all_pkgs::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             is_load,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] word_addr,
  output logic [WIDTH-1:0] wdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] load_data,
  output logic             fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign word_addr = {addr[WIDTH-1:2], 2'b00};
  assign byte_sel  = rdata[{addr[1:0], 3'b000} +: 8];
  assign half_sel  = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned; otherwise synthesis infers a latch to hold the old value.
    load_data = '0;
    wdata     = '0;
    be        = 4'b0000;
    fault     = 1'b0;

    if (is_load) begin
      unique case (funct3)
        F3_B:  load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
        F3_BU: load_data = {{(WIDTH-8){1'b0}}, byte_sel};
        F3_H: begin
          fault     = addr[0];
          load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
        end
        F3_HU: begin
          fault     = addr[0];
          load_data = {{(WIDTH-16){1'b0}}, half_sel};
        end
        F3_W: begin
          fault     = (addr[1:0] != 2'b00);
          load_data = rdata;
        end
        default: fault = 1'b1;
      endcase
    end else if (is_store) begin
      // Data is replicated to every lane; the byte enables pick the real target.
      unique case (funct3)
        F3_B: begin
          be    = 4'b0001 << addr[1:0];
          wdata = {(WIDTH/8){store_data[7:0]}};
        end
        F3_H: begin
          fault = addr[0];
          be    = 4'b0011 << addr[1:0];
          wdata = {(WIDTH/16){store_data[15:0]}};
        end
        F3_W: begin
          fault = (addr[1:0] != 2'b00);
          be    = 4'b1111;
          wdata = store_data;
        end
        default: fault = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory request handshake, stalls the
// front of the pipe until the access completes, and owns the MEM/WB register.
module mem_stage
  import all_pkgs::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] mem_alu_result,
  input  logic [WIDTH-1:0] mem_reg_data2,
  input  logic [4:0]       mem_rd,
  input  logic [2:0]       mem_funct3,
  input  logic [6:0]       mem_opcode,
  input  logic             mem_reg_wr_en,
  input  logic             mem_mem_to_reg,
  input  logic [1:0]       mem_wb_sel,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             mem_stall,
  output logic [WIDTH-1:0] wb_alu_result,
  output logic [WIDTH-1:0] wb_load_data,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_wr_en,
  output logic             wb_mem_to_reg,
  output logic [1:0]       wb_wb_sel,
  output logic             misaligned
);

  mem_state_e       state, state_next;
  logic             is_load, is_store;
  logic             align_fault;
  logic             mem_access;
  logic             load_done;
  logic [WIDTH-1:0] load_data;

  assign is_load    = (mem_opcode == OPC_LOAD);
  assign is_store   = (mem_opcode == OPC_STORE);
  assign mem_access = (is_load || is_store) && !align_fault;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (mem_funct3),
    .addr       (mem_alu_result),
    .store_data (mem_reg_data2),
    .rdata      (dmem_rdata),
    .word_addr  (dmem_addr),
    .wdata      (dmem_wdata),
    .be         (dmem_be),
    .load_data  (load_data),
    .fault      (align_fault)
  );

  // Address, data and enables come straight from EX/MEM, which the stall
  // freezes, so they stay stable while waiting for the grant.
  always_comb begin
    state_next = state;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    mem_stall  = 1'b0;
    load_done  = 1'b0;

    unique case (state)
      IDLE: begin
        if (mem_access) begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (!dmem_gnt) begin
            state_next = WAIT_GNT;
            mem_stall  = 1'b1;
          end else if (is_load) begin
            state_next = WAIT_RVALID;
            mem_stall  = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        mem_stall = 1'b1;
        if (dmem_gnt) begin
          if (is_store) begin
            state_next = IDLE;
            mem_stall  = 1'b0;
          end else begin
            state_next = WAIT_RVALID;
          end
        end
      end
      WAIT_RVALID: begin
        mem_stall = 1'b1;
        if (dmem_rvalid) begin
          state_next = IDLE;
          mem_stall  = 1'b0;
          load_done  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Reset wins combinationally too, so the request drops in the reset cycle.
    if (rst) begin
      state_next = IDLE;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      mem_stall  = 1'b0;
      load_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_alu_result <= '0;
      wb_load_data  <= '0;
      wb_rd         <= '0;
      wb_reg_wr_en  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_wb_sel     <= '0;
      misaligned    <= 1'b0;
    end else begin
      wb_alu_result <= mem_alu_result;
      wb_rd         <= mem_rd;
      wb_wb_sel     <= mem_wb_sel;
      misaligned    <= (state == IDLE) && (is_load || is_store) && align_fault;
      if (load_done) wb_load_data <= load_data;

      // Stall cycles and faulted accesses retire as bubbles.
      if (mem_stall || ((is_load || is_store) && align_fault)) begin
        wb_reg_wr_en  <= 1'b0;
        wb_mem_to_reg <= 1'b0;
      end else begin
        wb_reg_wr_en  <= mem_reg_wr_en && !is_store;
        wb_mem_to_reg <= mem_mem_to_reg && !is_store;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of single-cycle vectors plus
// hand-written multi-cycle load/store handshakes and a mid-transaction reset.
module tb_mem_stage;
  import all_pkgs::*;

  localparam logic [6:0] OPC_ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_alu_result, mem_reg_data2;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic [6:0]  mem_opcode;
  logic        mem_reg_wr_en, mem_mem_to_reg;
  logic [1:0]  mem_wb_sel;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] wb_alu_result, wb_load_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_wr_en, wb_mem_to_reg;
  logic [1:0]  wb_wb_sel;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .mem_alu_result (mem_alu_result),
    .mem_reg_data2  (mem_reg_data2),
    .mem_rd         (mem_rd),
    .mem_funct3     (mem_funct3),
    .mem_opcode     (mem_opcode),
    .mem_reg_wr_en  (mem_reg_wr_en),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_wb_sel     (mem_wb_sel),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_gnt       (dmem_gnt),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .mem_stall      (mem_stall),
    .wb_alu_result  (wb_alu_result),
    .wb_load_data   (wb_load_data),
    .wb_rd          (wb_rd),
    .wb_reg_wr_en   (wb_reg_wr_en),
    .wb_mem_to_reg  (wb_mem_to_reg),
    .wb_wb_sel      (wb_wb_sel),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exp_req;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_wr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic drive_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input logic m2r);
    mem_opcode     = opc;
    mem_funct3     = f3;
    mem_alu_result = addr;
    mem_reg_data2  = data;
    mem_rd         = rd;
    mem_reg_wr_en  = 1'b1;
    mem_mem_to_reg = m2r;
    mem_wb_sel     = 2'b01;
  endtask

  // Runs one aligned load/store with the given grant and rvalid delays.
  // Called on a negedge; returns on the negedge after completion.
  task automatic run_mem(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                         input int gnt_dly, input int rv_dly, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_load, input int exp_stalls);
    int  stalls   = 0;
    int  wait_cnt = 0;
    bit  granted  = 0;
    bit  done     = 0;
    drive_op(st ? OPC_STORE : OPC_LOAD, f3, addr, data, 5'd9, !st);
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      if (!granted) begin
        dmem_gnt    = (wait_cnt == gnt_dly);
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'hDEAD_DEAD;
      end else begin
        dmem_gnt    = 1'b0;
        dmem_rvalid = (wait_cnt == rv_dly);
        dmem_rdata  = dmem_rvalid ? rdata : 32'hDEAD_DEAD;
      end
      #1;
      if (!granted) begin
        check({name, " req"}, 32'(dmem_req), 32'd1);
        check({name, " we"}, 32'(dmem_we), 32'(st));
        check({name, " addr"}, dmem_addr, {addr[31:2], 2'b00});
        if (st) begin
          check({name, " be"}, 32'(dmem_be), 32'(exp_be));
          check({name, " wdata"}, dmem_wdata, exp_wdata);
        end
      end else begin
        check({name, " req low in WAIT_RVALID"}, 32'(dmem_req), 32'd0);
      end
      if (mem_stall) stalls++;
      if (!granted && dmem_gnt) begin
        granted  = 1;
        wait_cnt = 0;
        if (st) done = 1;
      end else if (granted && dmem_rvalid) begin
        done = 1;
      end else begin
        wait_cnt++;
      end
      @(posedge clk); #1;
      if (done) begin
        check({name, " wb_reg_wr_en"}, 32'(wb_reg_wr_en), 32'(!st));
        if (!st) begin
          check({name, " wb_load_data"}, wb_load_data, exp_load);
          check({name, " wb_mem_to_reg"}, 32'(wb_mem_to_reg), 32'd1);
        end
      end else begin
        check({name, " bubble wr_en"}, 32'(wb_reg_wr_en), 32'd0);
      end
      @(negedge clk);
    end
    if (!done) check({name, " timeout"}, 32'd0, 32'd1);
    check({name, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    // opc, f3, addr, data, rd, exp_req, exp_be, exp_wdata, exp_wr, exp_mis
    vecs[0]  = '{OPC_ALU,   3'b000, 32'h0000_1234, 32'h0, 5'd5,  1'b0, 4'h0, 32'h0,         1'b1, 1'b0};
    vecs[1]  = '{OPC_ALU,   3'b111, 32'hDEAD_BEEF, 32'h0, 5'd31, 1'b0, 4'h0, 32'h0,         1'b1, 1'b0};
    vecs[2]  = '{OPC_STORE, F3_B,   32'h0000_0101, 32'h0000_00A5, 5'd3, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0};
    vecs[3]  = '{OPC_STORE, F3_W,   32'h0000_0200, 32'h1234_5678, 5'd4, 1'b1, 4'b1111, 32'h1234_5678, 1'b0, 1'b0};
    vecs[4]  = '{OPC_LOAD,  F3_W,   32'h0000_0101, 32'h0, 5'd6,  1'b0, 4'h0, 32'h0,         1'b0, 1'b1};
    vecs[5]  = '{OPC_LOAD,  F3_H,   32'h0000_0103, 32'h0, 5'd7,  1'b0, 4'h0, 32'h0,         1'b0, 1'b1};
    vecs[6]  = '{OPC_ALU,   3'b000, 32'h0000_0042, 32'h0, 5'd1,  1'b0, 4'h0, 32'h0,         1'b1, 1'b0};
    vecs[7]  = '{OPC_LOAD,  3'b011, 32'h0000_0100, 32'h0, 5'd8,  1'b0, 4'h0, 32'h0,         1'b0, 1'b1};
    vecs[8]  = '{OPC_STORE, 3'b100, 32'h0000_0100, 32'h0, 5'd8,  1'b0, 4'h0, 32'h0,         1'b0, 1'b1};
    vecs[9]  = '{OPC_STORE, F3_H,   32'h0000_0102, 32'h0000_BEEF, 5'd2, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0};
    vecs[10] = '{OPC_STORE, F3_W,   32'h0000_0203, 32'h0, 5'd2,  1'b0, 4'h0, 32'h0,         1'b0, 1'b1};
    vecs[11] = '{OPC_STORE, F3_B,   32'h0000_0100, 32'hFFFF_FF12, 5'd2, 1'b1, 4'b0001, 32'h1212_1212, 1'b0, 1'b0};

    // Reset with an aligned store presented: nothing may be requested or stalled.
    rst         = 1'b1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    drive_op(OPC_STORE, F3_W, 32'h0000_0100, 32'h1111_2222, 5'd3, 1'b0);
    #1;
    check("reset req", 32'(dmem_req), 32'd0);
    check("reset stall", 32'(mem_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset wb_reg_wr_en", 32'(wb_reg_wr_en), 32'd0);
    check("reset wb_alu_result", wb_alu_result, 32'd0);
    check("reset misaligned", 32'(misaligned), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle vectors; a stray gnt/rvalid is always present and must not matter.
    for (int i = 0; i < 12; i++) begin
      drive_op(vecs[i].opc, vecs[i].f3, vecs[i].addr, vecs[i].data, vecs[i].rd, 1'b0);
      dmem_gnt    = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h5555_5555;
      #1;
      check($sformatf("vec%0d req", i), 32'(dmem_req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d stall", i), 32'(mem_stall), 32'd0);
      if (vecs[i].exp_req) begin
        check($sformatf("vec%0d be", i), 32'(dmem_be), 32'(vecs[i].exp_be));
        check($sformatf("vec%0d wdata", i), dmem_wdata, vecs[i].exp_wdata);
        check($sformatf("vec%0d addr", i), dmem_addr, {vecs[i].addr[31:2], 2'b00});
      end
      @(posedge clk); #1;
      check($sformatf("vec%0d wb_reg_wr_en", i), 32'(wb_reg_wr_en), 32'(vecs[i].exp_wr));
      check($sformatf("vec%0d misaligned", i), 32'(misaligned), 32'(vecs[i].exp_mis));
      check($sformatf("vec%0d wb_alu_result", i), wb_alu_result, vecs[i].addr);
      check($sformatf("vec%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
      @(negedge clk);
    end
    check("wb_wb_sel", 32'(wb_wb_sel), 32'd1);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;

    // Multi-cycle handshakes: name, st, f3, addr, data, rdata, gnt_dly, rv_dly, be, wdata, load, stalls
    run_mem("LB 0x103",  1'b0, F3_B,  32'h103, 32'h0, 32'h80FF_FFFF, 0, 0, 4'h0, 32'h0, 32'hFFFF_FF80, 1);
    run_mem("LBU 0x101", 1'b0, F3_BU, 32'h101, 32'h0, 32'h1234_80CD, 1, 2, 4'h0, 32'h0, 32'h0000_0080, 4);
    run_mem("LH 0x100",  1'b0, F3_H,  32'h100, 32'h0, 32'h1234_8001, 0, 1, 4'h0, 32'h0, 32'hFFFF_8001, 2);
    run_mem("LHU 0x102", 1'b0, F3_HU, 32'h102, 32'h0, 32'h80FF_1234, 2, 0, 4'h0, 32'h0, 32'h0000_80FF, 3);
    run_mem("SH gnt+3",  1'b1, F3_H,  32'h102, 32'h0000_BEEF, 32'h0, 3, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 3);
    run_mem("SW b2b",    1'b1, F3_W,  32'h300, 32'hCAFE_F00D, 32'h0, 0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0, 0);
    run_mem("LW b2b",    1'b0, F3_W,  32'h304, 32'h0, 32'h0BAD_F00D, 0, 0, 4'h0, 32'h0, 32'h0BAD_F00D, 1);

    // Reset while a LHU waits for rvalid; the late rvalid must be ignored.
    drive_op(OPC_LOAD, F3_HU, 32'h102, 32'h0, 5'd12, 1'b1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    check("rst seq stall before reset", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rst seq req in reset", 32'(dmem_req), 32'd0);
    check("rst seq stall in reset", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    check("rst seq wb_load_data cleared", wb_load_data, 32'd0);
    check("rst seq wb_reg_wr_en cleared", 32'(wb_reg_wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_op(OPC_ALU, 3'b000, 32'h0000_0777, 32'h0, 5'd7, 1'b0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hAAAA_AAAA;
    #1;
    check("rst seq req after reset", 32'(dmem_req), 32'd0);
    check("rst seq stall after reset", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    check("rst seq late rvalid ignored", wb_load_data, 32'd0);
    check("rst seq alu after reset", wb_alu_result, 32'h0000_0777);
    check("rst seq alu wr_en", 32'(wb_reg_wr_en), 32'd1);
    @(negedge clk);
    dmem_rvalid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
